// File: rtl/rx_pkg.sv
// Shared RX/TX definitions for the 4-ASK link: symbol encodings, nominal
// levels and the error saturation helper.
package rx_pkg;

    localparam int RX_WIDTH = 18;

    localparam logic [1:0] SYM_M3 = 2'b00;
    localparam logic [1:0] SYM_M1 = 2'b01;
    localparam logic [1:0] SYM_P1 = 2'b10;
    localparam logic [1:0] SYM_P3 = 2'b11;

    // Nominal inner level a = 0.25 and the initial threshold 2a.
    localparam logic signed [RX_WIDTH-1:0] A_NOM        = 18'sd32768;
    localparam logic signed [RX_WIDTH-1:0] REF_INIT_DEF = 18'sd65536;

    // Clamp a two-bit-wider signed value into the RX_WIDTH signed range.
    function automatic logic signed [RX_WIDTH-1:0] sat_err(input logic signed [RX_WIDTH+1:0] v);
        logic signed [RX_WIDTH+1:0] hi;
        logic signed [RX_WIDTH+1:0] lo;
        hi = {3'b000, {(RX_WIDTH-1){1'b1}}};
        lo = {3'b111, {(RX_WIDTH-1){1'b0}}};
        if (v > hi)
            return hi[RX_WIDTH-1:0];
        else if (v < lo)
            return lo[RX_WIDTH-1:0];
        return v[RX_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/rx_ref_level_est.sv
// Running reference-level estimator: averages |y| over 2^AVG_LOG2 decided
// samples and publishes the mean as the slicer threshold. Never reports 0.
module rx_ref_level_est
    import rx_pkg::*;
#(
    parameter int                 WIDTH    = 18,
    parameter int                 AVG_LOG2 = 10,
    parameter logic [WIDTH-1:0]   REF_INIT = REF_INIT_DEF
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  in_v,
    input  logic signed [WIDTH-1:0] in_y,
    output logic [WIDTH-1:0]      ref_level
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]          abs_y;
    logic [WIDTH+AVG_LOG2-1:0] acc;
    logic [WIDTH+AVG_LOG2-1:0] sum;
    logic [AVG_LOG2-1:0]       cnt;
    logic [WIDTH-1:0]          mean;

    // Magnitude of the input; the most negative code saturates to full scale.
    always_comb begin
        abs_y = in_y;
        if (in_y[WIDTH-1])
            abs_y = (in_y == MIN_NEG) ? MAX_POS : -in_y;
        sum  = acc + {{AVG_LOG2{1'b0}}, abs_y};
        mean = sum[WIDTH+AVG_LOG2-1:AVG_LOG2];
    end

    // Accumulate per sample; on the last sample of the window publish the mean.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            ref_level <= REF_INIT;
        end else if (in_v) begin
            if (&cnt) begin
                acc       <= '0;
                cnt       <= '0;
                ref_level <= (mean == '0) ? ONE : mean;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_symbol_slicer.sv
// 4-ASK decision device: picks one sample per symbol at phase_sel, slices it
// against the adaptive threshold and reports symbol, slicer error and the
// reference level. sym_valid is a one-cycle pulse with no back-pressure;
// sym_out/err_out are valid in that cycle and hold until the next pulse.
module rx_symbol_slicer
    import rx_pkg::*;
#(
    parameter int                       WIDTH      = 18,
    parameter int                       OVERSAMPLE = 4,
    parameter int                       AVG_LOG2   = 10,
    parameter logic signed [WIDTH-1:0]  REF_INIT   = REF_INIT_DEF,
    localparam int                      PH_W       = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sam_clk_en,
    input  logic                    sym_clk_en,
    input  logic [PH_W-1:0]         phase_sel,
    input  logic signed [WIDTH-1:0] y_in,
    output logic [1:0]              sym_out,
    output logic                    sym_valid,
    output logic signed [WIDTH-1:0] err_out,
    output logic [WIDTH-1:0]        ref_level
);

    localparam logic [PH_W-1:0] PH_ONE = {{(PH_W-1){1'b0}}, 1'b1};

    logic [PH_W-1:0]          ph;
    logic [PH_W-1:0]          cur_ph;
    logic signed [WIDTH-1:0]  y_cap;
    logic                     cap_v;

    logic signed [WIDTH+1:0]  y_w;
    logic signed [WIDTH+1:0]  r_w;
    logic signed [WIDTH+1:0]  a_w;
    logic signed [WIDTH+1:0]  outer_w;
    logic signed [WIDTH+1:0]  lvl_w;
    logic signed [WIDTH+1:0]  diff_w;
    logic [1:0]               sym_d;

    // The symbol strobe marks phase 0; the counter then runs from 1.
    assign cur_ph = sym_clk_en ? '0 : ph;

    // Phase counter advances on samples only; a bare symbol strobe is ignored.
    always_ff @(posedge sys_clk) begin
        if (reset)
            ph <= '0;
        else if (sam_clk_en)
            ph <= sym_clk_en ? PH_ONE : ph + PH_ONE;
    end

    // Capture the sample at the selected phase.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cap_v <= 1'b0;
            y_cap <= '0;
        end else begin
            cap_v <= sam_clk_en && (cur_ph == phase_sel);
            if (sam_clk_en && (cur_ph == phase_sel))
                y_cap <= y_in;
        end
    end

    // Slice against +/-R and form the error against the ideal level.
    always_comb begin
        y_w     = {{2{y_cap[WIDTH-1]}}, y_cap};
        r_w     = {2'b00, ref_level};
        a_w     = r_w >>> 1;
        outer_w = r_w + a_w;
        sym_d   = SYM_M3;
        lvl_w   = -outer_w;
        if (y_w >= r_w) begin
            sym_d = SYM_P3;
            lvl_w = outer_w;
        end else if (!y_cap[WIDTH-1]) begin
            sym_d = SYM_P1;
            lvl_w = a_w;
        end else if (y_w >= -r_w) begin
            sym_d = SYM_M1;
            lvl_w = -a_w;
        end
        diff_w = y_w - lvl_w;
    end

    // Register decision outputs; they hold between pulses.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sym_out   <= SYM_M3;
            sym_valid <= 1'b0;
            err_out   <= '0;
        end else begin
            sym_valid <= cap_v;
            if (cap_v) begin
                sym_out <= sym_d;
                err_out <= sat_err(diff_w);
            end
        end
    end

    rx_ref_level_est #(
        .WIDTH    (WIDTH),
        .AVG_LOG2 (AVG_LOG2),
        .REF_INIT (REF_INIT)
    ) u_ref_est (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .in_v      (cap_v),
        .in_y      (y_cap),
        .ref_level (ref_level)
    );

endmodule
